// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch sequencer. It holds the program counter, issues one memory
// read for each fetch_start, and hands the returned word to the instruction
// register with a single load_ir strobe. A fetch that goes unanswered for
// TIMEOUT cycles is abandoned, and a misaligned PC load is rejected. Either
// case produces a one-cycle fetch_err pulse.
//
// Ports
//   clk          single clock, all state updates on posedge
//   rst          asynchronous active-low reset
//   fetch_start  request one instruction fetch (sampled in IDLE only)
//   pc_load      load PC from pc_next (sampled in IDLE only)
//   pc_next      branch/jump target, must be word aligned
//   mem_req      memory read request, high in REQ/WAIT
//   mem_addr     memory read address, always equal to the PC
//   mem_rdata    memory read data
//   mem_ready    mem_rdata valid this cycle
//   inst_out     last fetched instruction, feeds the IR
//   load_ir      IR load strobe, exactly one cycle in LOAD
//   pc_out       PC of the instruction held in inst_out
//   busy         high whenever the FSM is not in IDLE
//   fetch_err    one-cycle pulse on timeout or misaligned pc_next
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for fetch_start; pc_load accepted here only
// REQ    | first request cycle, wait counter freshly cleared
// WAIT   | request held, counting cycles without mem_ready
// LOAD   | instruction captured, load_ir high for this one cycle
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter int                   BUS_WIDTH = 32,
   parameter logic [BUS_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
   parameter int                   TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fetch_start,
   input  logic                 pc_load,
   input  logic [BUS_WIDTH-1:0] pc_next,
   output logic                 mem_req,
   output logic [BUS_WIDTH-1:0] mem_addr,
   input  logic [BUS_WIDTH-1:0] mem_rdata,
   input  logic                 mem_ready,
   output logic [BUS_WIDTH-1:0] inst_out,
   output logic                 load_ir,
   output logic [BUS_WIDTH-1:0] pc_out,
   output logic                 busy,
   output logic                 fetch_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_LOAD = 2'd3
   } state_t;

   state_t             state;
   logic [BUS_WIDTH-1:0] pc;
   logic [CNT_W-1:0]     wait_cnt;
   logic                 pc_next_misaligned;

   assign pc_next_misaligned = (pc_next[1:0] != 2'b00);

   // The address bus is the PC itself. After a successful fetch it already
   // shows the next sequential address while mem_req is low.
   assign mem_addr = pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         pc        <= RESET_PC;
         pc_out    <= RESET_PC;
         inst_out  <= '0;
         load_ir   <= 1'b0;
         mem_req   <= 1'b0;
         busy      <= 1'b0;
         fetch_err <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         // Both strobes are single-cycle unless re-asserted below.
         load_ir   <= 1'b0;
         fetch_err <= 1'b0;

         case (state)
            S_IDLE: begin
               if (pc_load && pc_next_misaligned) begin
                  // A rejected load also cancels a fetch requested in the
                  // same cycle, so the fetch never runs from a stale PC.
                  fetch_err <= 1'b1;
               end else begin
                  if (pc_load) begin
                     pc <= pc_next;
                  end
                  if (fetch_start) begin
                     state    <= S_REQ;
                     mem_req  <= 1'b1;
                     busy     <= 1'b1;
                     wait_cnt <= '0;
                  end
               end
            end

            S_REQ, S_WAIT: begin
               if (mem_ready) begin
                  inst_out <= mem_rdata;
                  pc_out   <= pc;
                  pc       <= pc + BUS_WIDTH'(4);
                  mem_req  <= 1'b0;
                  load_ir  <= 1'b1;
                  state    <= S_LOAD;
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  // This idle cycle brings the count to TIMEOUT: give up.
                  wait_cnt  <= wait_cnt + CNT_W'(1);
                  mem_req   <= 1'b0;
                  busy      <= 1'b0;
                  fetch_err <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
                  state    <= S_WAIT;
               end
            end

            S_LOAD: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               mem_req <= 1'b0;
               busy    <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start;
   logic        pc_load;
   logic [31:0] pc_next;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [31:0] inst_out;
   logic        load_ir;
   logic [31:0] pc_out;
   logic        busy;
   logic        fetch_err;

   int n_checks = 0;
   int n_errors = 0;

   // Transaction-level reference state.
   logic [31:0] m_pc;
   logic [31:0] m_inst;
   logic [31:0] m_pcout;

   inst_fetch #(
      .BUS_WIDTH (32),
      .RESET_PC  (32'h0000_0000),
      .TIMEOUT   (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_start (fetch_start),
      .pc_load     (pc_load),
      .pc_next     (pc_next),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .inst_out    (inst_out),
      .load_ir     (load_ir),
      .pc_out      (pc_out),
      .busy        (busy),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        pc_load;
      logic [31:0] pc_next;
      logic        mem_ready;
      logic [31:0] exp_addr;
      logic        exp_err;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s got %h want %h", name, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      fetch_start = 1'b0;
      pc_load     = 1'b0;
      pc_next     = 32'h0;
      mem_ready   = 1'b0;
      mem_rdata   = 32'h0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".mem_req"}, {31'b0, mem_req}, 32'd0);
      chk({tag, ".busy"},    {31'b0, busy},    32'd0);
      chk({tag, ".load_ir"}, {31'b0, load_ir}, 32'd0);
      chk({tag, ".addr"},    mem_addr,         m_pc);
      chk({tag, ".inst"},    inst_out,         m_inst);
      chk({tag, ".pc_out"},  pc_out,           m_pcout);
   endtask

   // One fetch request, answered after d unanswered cycles (d >= TO never
   // answers). With noise set, fetch_start/pc_load/mem_rdata toggle randomly
   // while the block is busy, which must have no effect.
   task automatic do_fetch(input logic ld, input logic [31:0] nxt, input int d,
                           input logic [31:0] data, input bit noise);
      fetch_start = 1'b1;
      pc_load     = ld;
      pc_next     = nxt;
      mem_ready   = 1'b0;
      step();
      fetch_start = 1'b0;
      pc_load     = 1'b0;
      if (ld && nxt[1:0] != 2'b00) begin
         chk("misaligned.err", {31'b0, fetch_err}, 32'd1);
         chk_idle_outputs("misaligned");
         step();
         chk("misaligned.err_off", {31'b0, fetch_err}, 32'd0);
         chk_idle_outputs("misaligned_after");
         clear_inputs();
         return;
      end
      if (ld) m_pc = nxt;
      chk("req.mem_req", {31'b0, mem_req}, 32'd1);
      chk("req.busy",    {31'b0, busy},    32'd1);
      chk("req.addr",    mem_addr,         m_pc);
      for (int k = 0; k < TO; k++) begin
         mem_ready = (k == d);
         mem_rdata = (k == d) ? data : $urandom;
         if (noise) begin
            fetch_start = 1'($urandom_range(0, 1));
            pc_load     = 1'($urandom_range(0, 1));
            pc_next     = $urandom;
         end
         step();
         if (k == d) begin
            m_pcout = m_pc;
            m_inst  = data;
            m_pc    = m_pc + 32'd4;
            chk("load.load_ir", {31'b0, load_ir}, 32'd1);
            chk("load.inst",    inst_out,         m_inst);
            chk("load.pc_out",  pc_out,           m_pcout);
            chk("load.addr",    mem_addr,         m_pc);
            chk("load.mem_req", {31'b0, mem_req}, 32'd0);
            chk("load.busy",    {31'b0, busy},    32'd1);
            mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
            step();
            chk("post_load.err", {31'b0, fetch_err}, 32'd0);
            chk_idle_outputs("post_load");
            break;
         end else if (k == TO - 1) begin
            chk("timeout.err", {31'b0, fetch_err}, 32'd1);
            chk_idle_outputs("timeout");
            break;
         end else begin
            chk("wait.mem_req", {31'b0, mem_req}, 32'd1);
            chk("wait.addr",    mem_addr,         m_pc);
            chk("wait.load_ir", {31'b0, load_ir}, 32'd0);
            chk("wait.err",     {31'b0, fetch_err}, 32'd0);
         end
      end
      clear_inputs();
   endtask

   task automatic idle_cycle(input logic ld, input logic [31:0] nxt);
      logic want_err;
      pc_load   = ld;
      pc_next   = nxt;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      step();
      want_err = ld && (nxt[1:0] != 2'b00);
      if (ld && !want_err) m_pc = nxt;
      chk("idle.err", {31'b0, fetch_err}, {31'b0, want_err});
      chk_idle_outputs("idle");
      clear_inputs();
   endtask

   initial begin
      vecs[0] = '{pc_load: 1'b0, pc_next: 32'h0000_0000, mem_ready: 1'b1, exp_addr: 32'h0000_0004, exp_err: 1'b0};
      vecs[1] = '{pc_load: 1'b1, pc_next: 32'h0000_0040, mem_ready: 1'b0, exp_addr: 32'h0000_0040, exp_err: 1'b0};
      vecs[2] = '{pc_load: 1'b1, pc_next: 32'h0000_0041, mem_ready: 1'b0, exp_addr: 32'h0000_0040, exp_err: 1'b1};
      vecs[3] = '{pc_load: 1'b0, pc_next: 32'h0000_0000, mem_ready: 1'b1, exp_addr: 32'h0000_0040, exp_err: 1'b0};
      vecs[4] = '{pc_load: 1'b1, pc_next: 32'h0000_0043, mem_ready: 1'b1, exp_addr: 32'h0000_0040, exp_err: 1'b1};
      vecs[5] = '{pc_load: 1'b1, pc_next: 32'h0000_0080, mem_ready: 1'b0, exp_addr: 32'h0000_0080, exp_err: 1'b0};
      vecs[6] = '{pc_load: 1'b1, pc_next: 32'h0000_0002, mem_ready: 1'b0, exp_addr: 32'h0000_0080, exp_err: 1'b1};
      vecs[7] = '{pc_load: 1'b1, pc_next: 32'hFFFF_FFFC, mem_ready: 1'b0, exp_addr: 32'hFFFF_FFFC, exp_err: 1'b0};

      clear_inputs();
      rst = 1'b0;
      m_pc = 32'h0; m_inst = 32'h0; m_pcout = 32'h0;
      step();
      step();
      chk("reset.err", {31'b0, fetch_err}, 32'd0);
      chk_idle_outputs("reset");
      rst = 1'b1;
      step();
      chk_idle_outputs("reset_release");

      // Minimum latency fetch: load_ir two edges after fetch_start.
      do_fetch(1'b0, 32'h0, 0, 32'h0050_0093, 1'b0);
      chk("first.inst",   inst_out, 32'h0050_0093);
      chk("first.pc_out", pc_out,   32'h0000_0000);
      chk("first.pc",     mem_addr, 32'h0000_0004);

      // Idle-state vectors: PC loads, misalignment, ignored mem_ready.
      for (int i = 0; i < 8; i++) begin
         pc_load   = vecs[i].pc_load;
         pc_next   = vecs[i].pc_next;
         mem_ready = vecs[i].mem_ready;
         mem_rdata = 32'hDEAD_BEEF;
         step();
         chk($sformatf("vec%0d.addr", i),    mem_addr,           vecs[i].exp_addr);
         chk($sformatf("vec%0d.err", i),     {31'b0, fetch_err}, {31'b0, vecs[i].exp_err});
         chk($sformatf("vec%0d.load_ir", i), {31'b0, load_ir},   32'd0);
         chk($sformatf("vec%0d.busy", i),    {31'b0, busy},      32'd0);
         chk($sformatf("vec%0d.inst", i),    inst_out,           32'h0050_0093);
      end
      clear_inputs();
      m_pc = 32'hFFFF_FFFC;

      // Wrap-around of PC.
      do_fetch(1'b0, 32'h0, 3, 32'h1234_5678, 1'b0);
      chk("wrap.pc",     mem_addr, 32'h0000_0000);
      chk("wrap.pc_out", pc_out,   32'hFFFF_FFFC);

      // Response after 5 idle cycles.
      do_fetch(1'b0, 32'h0, 5, 32'hA5A5_0001, 1'b0);
      chk("delay5.pc", mem_addr, 32'h0000_0004);

      // Load and fetch together, aligned then misaligned.
      do_fetch(1'b1, 32'h0000_0100, 2, 32'h0000_0013, 1'b0);
      chk("ldfetch.pc_out", pc_out, 32'h0000_0100);
      do_fetch(1'b1, 32'h0000_0102, 0, 32'h0, 1'b0);
      chk("ldfetch_mis.pc", mem_addr, 32'h0000_0104);

      // Never answered: timeout, PC unchanged.
      do_fetch(1'b0, 32'h0, TO + 5, 32'h0, 1'b0);
      chk("timeout.pc", mem_addr, 32'h0000_0104);

      // Answered on the last allowed cycle.
      do_fetch(1'b0, 32'h0, TO - 1, 32'h0BAD_CAFE, 1'b0);
      chk("lastcycle.inst", inst_out, 32'h0BAD_CAFE);

      // Reset during WAIT.
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      step();
      step();
      chk("rstwait.in_wait", {31'b0, mem_req}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      m_pc = 32'h0; m_inst = 32'h0; m_pcout = 32'h0;
      chk("rstwait.err", {31'b0, fetch_err}, 32'd0);
      chk_idle_outputs("rstwait");
      @(posedge clk);
      #1;
      rst = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = 32'hFFFF_0000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rstwait_after.err", {31'b0, fetch_err}, 32'd0);
         chk_idle_outputs("rstwait_after");
      end
      clear_inputs();

      // Randomised mix against the reference model.
      for (int i = 0; i < 40; i++) begin
         logic        ld;
         logic [31:0] nxt;
         int          op;
         ld  = 1'($urandom_range(0, 1));
         nxt = $urandom;
         if ($urandom_range(0, 3) != 0) nxt[1:0] = 2'b00;
         op = $urandom_range(0, 2);
         if (op == 0) idle_cycle(ld, nxt);
         else do_fetch(ld, nxt, $urandom_range(0, TO + 2), $urandom, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
